wave_seq_ctrl: RTL and testbench

Sequencer for the function generator's waveform lookup tables. A phase accumulator produces the shared 8-bit table address. The block selects one of four table outputs and registers it as the output sample. Frequency, waveform and one-shot settings arrive through a valid/ready config port and take effect glitch-free, at a phase wrap.

---
 rtl/wave_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_wave_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_seq_ctrl.sv
// Waveform table sequencer: phase accumulator drives a shared LUT address, one of four
// table outputs is registered as the sample. States: IDLE (held) | RUN (stepping) | DONE (one-shot finished)
module wave_seq_ctrl #(
    parameter int ACC_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [ACC_W-1:0]    cfg_inc_i,
    input  logic [1:0]          cfg_wave_i,
    input  logic                cfg_oneshot_i,
    output logic [7:0]          lut_addr_o,
    input  logic [4*DATA_W-1:0] lut_data_i,
    output logic [DATA_W-1:0]   sample_o,
    output logic                sample_valid_o,
    output logic                wrap_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    inc_q, inc_d;
    logic [1:0]          wave_q, wave_d;
    logic                oneshot_q, oneshot_d;
    logic                pend_valid_q, pend_valid_d;
    logic [ACC_W-1:0]    pend_inc_q, pend_inc_d;
    logic [1:0]          pend_wave_q, pend_wave_d;
    logic                pend_oneshot_q, pend_oneshot_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                wrap_q, wrap_d;

    logic [ACC_W:0]      sum_w;
    logic                carry_w;
    logic                accept_w;
    logic                apply_w;
    logic [DATA_W-1:0]   sel_data_w;

    assign sum_w       = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry_w     = sum_w[ACC_W];
    assign cfg_ready_o = !pend_valid_q;
    assign accept_w    = cfg_valid_i && !pend_valid_q;
    assign lut_addr_o  = acc_q[ACC_W-1 -: 8];

    always_comb begin
        sel_data_w = lut_data_i[DATA_W-1:0];
        case (wave_q)
            2'd0:    sel_data_w = lut_data_i[0*DATA_W +: DATA_W];
            2'd1:    sel_data_w = lut_data_i[1*DATA_W +: DATA_W];
            2'd2:    sel_data_w = lut_data_i[2*DATA_W +: DATA_W];
            default: sel_data_w = lut_data_i[3*DATA_W +: DATA_W];
        endcase
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        inc_d          = inc_q;
        wave_d         = wave_q;
        oneshot_d      = oneshot_q;
        pend_valid_d   = pend_valid_q;
        pend_inc_d     = pend_inc_q;
        pend_wave_d    = pend_wave_q;
        pend_oneshot_d = pend_oneshot_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        wrap_d         = 1'b0;
        apply_w        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                apply_w = pend_valid_q;
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    sample_d       = sel_data_w;
                    sample_valid_d = 1'b1;
                    acc_d          = sum_w[ACC_W-1:0];
                    // Settings only change at a period boundary so no period is ever mixed.
                    if (carry_w) begin
                        wrap_d  = 1'b1;
                        apply_w = pend_valid_q;
                        if (oneshot_q) begin
                            state_d = ST_DONE;
                            acc_d   = '0;
                        end
                    end
                end
            end
            ST_DONE: begin
                apply_w = pend_valid_q;
                if (!en_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (apply_w) begin
            inc_d        = pend_inc_q;
            wave_d       = pend_wave_q;
            oneshot_d    = pend_oneshot_q;
            pend_valid_d = 1'b0;
        end
        if (accept_w) begin
            pend_inc_d     = cfg_inc_i;
            pend_wave_d    = cfg_wave_i;
            pend_oneshot_d = cfg_oneshot_i;
            pend_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            inc_q          <= '0;
            wave_q         <= 2'd0;
            oneshot_q      <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_inc_q     <= '0;
            pend_wave_q    <= 2'd0;
            pend_oneshot_q <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            inc_q          <= inc_d;
            wave_q         <= wave_d;
            oneshot_q      <= oneshot_d;
            pend_valid_q   <= pend_valid_d;
            pend_inc_q     <= pend_inc_d;
            pend_wave_q    <= pend_wave_d;
            pend_oneshot_q <= pend_oneshot_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            wrap_q         <= wrap_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign wrap_o         = wrap_q;
    assign busy_o         = (state_q == ST_RUN);

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: table-driven one-shot periods plus
// hand-written sequences for reconfiguration, pause, inc=0 and async reset.
module tb_wave_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [15:0] cfg_inc_i = '0;
    logic [1:0]  cfg_wave_i = '0;
    logic        cfg_oneshot_i = 1'b0;
    logic [7:0]  lut_addr_o;
    logic [31:0] lut_data_i;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic        wrap_o;
    logic        busy_o;

    wave_seq_ctrl #(.ACC_W(16), .DATA_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_inc_i(cfg_inc_i), .cfg_wave_i(cfg_wave_i), .cfg_oneshot_i(cfg_oneshot_i),
        .lut_addr_o(lut_addr_o), .lut_data_i(lut_data_i),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o),
        .wrap_o(wrap_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] lut_model(input logic [1:0] w, input logic [7:0] a);
        logic [7:0] r;
        case (w)
            2'd0:    r = a;
            2'd1:    r = a[7] ? {~a[6:0], 1'b0} : {a[6:0], 1'b0};
            2'd2:    r = a[7] ? 8'hFF : 8'h00;
            default: r = a ^ 8'hA5;
        endcase
        return r;
    endfunction

    assign lut_data_i = {lut_model(2'd3, lut_addr_o), lut_model(2'd2, lut_addr_o),
                         lut_model(2'd1, lut_addr_o), lut_model(2'd0, lut_addr_o)};

    typedef struct { logic [7:0] s; logic w; } exp_t;
    exp_t exp_q[$];
    int   wrap_cyc[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sample_cnt = 0;
    int wrap_cnt = 0;
    int first_cyc = 0;
    bit sb_en = 1'b1;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Scoreboard consumer: every valid sample pops one expectation.
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_i) begin
            if (sample_valid_o) begin
                if (sample_cnt == 0) first_cyc = cyc;
                sample_cnt++;
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_underflow: got sample 0x%0h with no expectation", sample_o);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (sample_o !== e.s || wrap_o !== e.w) begin
                            failures++;
                            $display("FAIL sb_sample#%0d: got s=0x%0h w=%0b expected s=0x%0h w=%0b",
                                     sample_cnt, sample_o, wrap_o, e.s, e.w);
                        end
                    end
                end
            end
            if (wrap_o) begin
                wrap_cnt++;
                wrap_cyc.push_back(cyc);
                if (!sample_valid_o) begin
                    checks++;
                    failures++;
                    $display("FAIL wrap_without_valid: got wrap=1 valid=0 expected valid=1");
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_mon();
        sample_cnt = 0;
        wrap_cnt = 0;
        wrap_cyc.delete();
        exp_q.delete();
    endtask

    // Caller is just after a negedge; returns just after the accepting posedge.
    task automatic send_cfg(input logic [15:0] inc, input logic [1:0] w, input logic os);
        int n;
        cfg_inc_i = inc;
        cfg_wave_i = w;
        cfg_oneshot_i = os;
        cfg_valid_i = 1'b1;
        n = 0;
        while (!cfg_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!cfg_ready_o) check("cfg_handshake_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        cfg_valid_i = 1'b0;
    endtask

    task automatic push_period(input logic [15:0] start, input logic [15:0] inc, input logic [1:0] w);
        logic [15:0] acc;
        logic [16:0] sum;
        exp_t r;
        acc = start;
        for (int k = 0; k < 70000; k++) begin
            r.s = lut_model(w, acc[15:8]);
            sum = {1'b0, acc} + {1'b0, inc};
            r.w = sum[16];
            exp_q.push_back(r);
            if (sum[16]) break;
            acc = sum[15:0];
        end
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n = 0;
        while (busy_o && n < maxc) begin
            tick();
            n++;
        end
        if (busy_o) check(nm, 1, 0);
    endtask

    task automatic wait_addr(input logic [7:0] a, input int maxc, input string nm);
        int n = 0;
        while (lut_addr_o != a && n < maxc) begin
            tick();
            n++;
        end
        if (lut_addr_o != a) check(nm, lut_addr_o, a);
    endtask

    typedef struct {
        logic [15:0] inc;
        logic [1:0]  wave;
        int          exp_count;
        logic [7:0]  exp_last;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int bad;
        vecs[0] = '{16'h0800, 2'd0, 32, 8'hF8};
        vecs[1] = '{16'h1000, 2'd1, 16, 8'h1E};
        vecs[2] = '{16'h2000, 2'd2,  8, 8'hFF};
        vecs[3] = '{16'h4000, 2'd3,  4, 8'h65};
        vecs[4] = '{16'h8000, 2'd0,  2, 8'h80};
        vecs[5] = '{16'hC000, 2'd0,  2, 8'hC0};

        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("rst_sample", sample_o, 0);
        check("rst_valid", sample_valid_o, 0);
        check("rst_wrap", wrap_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cfg_ready", cfg_ready_o, 1);
        check("rst_lut_addr", lut_addr_o, 0);

        // One-shot periods, one table entry per record.
        foreach (vecs[i]) begin
            send_cfg(vecs[i].inc, vecs[i].wave, 1'b1);
            tick();
            tick();
            clear_mon();
            push_period(16'h0000, vecs[i].inc, vecs[i].wave);
            en_i = 1'b1;
            tick();
            tick();
            wait_done(2000, "vec_done_timeout");
            check($sformatf("vec%0d_count", i), sample_cnt, vecs[i].exp_count);
            check($sformatf("vec%0d_wraps", i), wrap_cnt, 1);
            check($sformatf("vec%0d_held", i), sample_o, vecs[i].exp_last);
            tick();
            check($sformatf("vec%0d_valid_done", i), sample_valid_o, 0);
            check($sformatf("vec%0d_held2", i), sample_o, vecs[i].exp_last);
            en_i = 1'b0;
            tick();
            tick();
        end

        // Free-running saw, then a mid-period reconfiguration that lands at the wrap.
        send_cfg(16'h0100, 2'd0, 1'b0);
        tick();
        tick();
        clear_mon();
        push_period(16'h0000, 16'h0100, 2'd0);
        push_period(16'h0000, 16'h0200, 2'd3);
        en_i = 1'b1;
        tick();
        wait_addr(8'h40, 400, "reconf_addr40_timeout");
        send_cfg(16'h0200, 2'd3, 1'b1);
        check("reconf_ready_low", cfg_ready_o, 0);
        wait_addr(8'h80, 400, "reconf_addr80_timeout");
        check("reconf_ready_still_low", cfg_ready_o, 0);
        check("reconf_busy", busy_o, 1);
        wait_done(1000, "reconf_done_timeout");
        check("reconf_count", sample_cnt, 384);
        check("reconf_wraps", wrap_cnt, 2);
        check("reconf_queue_empty", exp_q.size(), 0);
        if (wrap_cyc.size() == 2) begin
            check("reconf_period1_len", wrap_cyc[0] - first_cyc, 255);
            check("reconf_period2_len", wrap_cyc[1] - wrap_cyc[0], 128);
        end else begin
            check("reconf_wrap_list", wrap_cyc.size(), 2);
        end
        check("reconf_ready_back", cfg_ready_o, 1);
        check("reconf_held", sample_o, 8'h5B);
        en_i = 1'b0;
        tick();
        tick();

        // Pause at 0x37 for five cycles, then resume; the period must still be 256 samples.
        send_cfg(16'h0100, 2'd1, 1'b1);
        tick();
        tick();
        clear_mon();
        push_period(16'h0000, 16'h0100, 2'd1);
        en_i = 1'b1;
        tick();
        wait_addr(8'h37, 400, "pause_addr_timeout");
        en_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pause_valid", sample_valid_o, 0);
            check("pause_addr", lut_addr_o, 8'h37);
        end
        check("pause_busy", busy_o, 0);
        en_i = 1'b1;
        tick();
        tick();
        wait_done(1000, "pause_done_timeout");
        check("pause_count", sample_cnt, 256);
        check("pause_wraps", wrap_cnt, 1);
        check("pause_queue_empty", exp_q.size(), 0);
        en_i = 1'b0;
        tick();
        tick();

        // inc=0 applied at a wrap: acc freezes at 0x0200, table 3 -> 0xA7 forever.
        sb_en = 1'b0;
        send_cfg(16'h0300, 2'd3, 1'b0);
        tick();
        tick();
        clear_mon();
        en_i = 1'b1;
        tick();
        tick();
        send_cfg(16'h0000, 2'd3, 1'b0);
        check("inc0_pending", cfg_ready_o, 0);
        begin
            int n = 0;
            while (wrap_cnt == 0 && n < 200) begin
                tick();
                n++;
            end
        end
        check("inc0_first_wrap", wrap_cnt, 1);
        check("inc0_applied_ready", cfg_ready_o, 1);
        wrap_cnt = 0;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (k == 100) send_cfg(16'h0100, 2'd0, 1'b0);
            if (!sample_valid_o || sample_o != 8'hA7) bad++;
        end
        check("inc0_bad_samples", bad, 0);
        check("inc0_no_wrap", wrap_cnt, 0);
        check("inc0_ready_stuck_low", cfg_ready_o, 0);
        check("inc0_addr", lut_addr_o, 8'h02);
        check("inc0_busy", busy_o, 1);

        // Asynchronous reset mid-cycle with the pending slot full.
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_sample", sample_o, 0);
        check("arst_valid", sample_valid_o, 0);
        check("arst_wrap", wrap_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_cfg_ready", cfg_ready_o, 1);
        check("arst_lut_addr", lut_addr_o, 0);
        tick();
        rst_i = 1'b0;
        tick();
        repeat (5) tick();
        check("arst_pending_dropped", lut_addr_o, 0);
        check("arst_run_busy", busy_o, 1);
        check("arst_ready_after", cfg_ready_o, 1);
        en_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
